// File: rtl/output_pack_writer.sv
// output_pack_writer
//   Packs a stream of pooled output elements into SRAM words and writes them
//   at consecutive addresses starting from a per-frame base address.
//   Lane 0 of each word occupies the most significant element slot. A word is
//   closed when its last lane is filled, or early on in_last, in which case
//   the unfilled lanes are zero-filled.
//
//   Optional feature: define OUTPUT_PACK_WORD_COUNT_EN to add the
//   words_written output, a saturating per-frame count of committed writes.
//
// Ports
//   clk                 : clock, rising edge
//   reset_b             : asynchronous active-low reset
//   frame_start         : one-cycle pulse opening a frame (honoured in IDLE only)
//   base_addr           : first word address of the frame
//   in_valid/in_ready   : element stream handshake
//   in_data             : element value
//   in_last             : marks the final element of the frame
//   sram_write_enable   : write request (driven from the pending flag)
//   sram_write_address  : word address of the pending write
//   sram_write_data     : packed word of the pending write
//   sram_ready          : SRAM grant; a write commits when enable and ready are 1
//   words_written       : committed words in the current/last frame (optional)
//   frame_done          : one-cycle pulse after the final commit of a frame
//   busy                : high whenever the writer is not IDLE
`timescale 1ns/1ps

module output_pack_writer #(
  parameter int ELEM_W         = 8,
  parameter int ELEMS_PER_WORD = 2,
  parameter int ADDR_W         = 12,
  localparam int WORD_W        = ELEM_W * ELEMS_PER_WORD
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [WORD_W-1:0] sram_write_data,
  input  logic              sram_ready,
`ifdef OUTPUT_PACK_WORD_COUNT_EN
  output logic [ADDR_W:0]   words_written,
`endif
  output logic              frame_done,
  output logic              busy
);

  localparam int LANE_W = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t              state;
  logic                pending;
  logic [LANE_W-1:0]   lane;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   build;
  logic                done_q;

  logic                commit;
  logic                accept;
  logic                close_word;
  logic [WORD_W-1:0]   merged;

  assign commit     = pending & sram_ready;
  // A new element may enter while the pending word leaves in the same cycle,
  // which keeps the stream at one element per cycle across word boundaries.
  assign in_ready   = (state == ACTIVE) && (!pending || sram_ready);
  assign accept     = in_valid & in_ready;
  assign close_word = accept && ((lane == LANE_W'(ELEMS_PER_WORD - 1)) || in_last);

  // Partial word with the incoming element dropped into its lane; lanes not
  // yet written are still zero in build, which gives the zero-fill on in_last.
  always_comb begin
    merged = build;
    for (int k = 0; k < ELEMS_PER_WORD; k++) begin
      if (lane == LANE_W'(k)) begin
        merged[WORD_W-1-k*ELEM_W -: ELEM_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= IDLE;
      pending <= 1'b0;
      lane    <= '0;
      addr    <= '0;
      word_q  <= '0;
      build   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (commit) begin
        addr <= addr + ADDR_W'(1);
      end

      // A word closing in the same cycle as a commit simply replaces it.
      if (close_word) begin
        word_q  <= merged;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      if (accept) begin
        lane  <= lane + LANE_W'(1);
        build <= close_word ? '0 : merged;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= ACTIVE;
            addr  <= base_addr;
            lane  <= '0;
            build <= '0;
          end
        end
        ACTIVE: begin
          if (accept && in_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (commit) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_PACK_WORD_COUNT_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      words_written <= '0;
    end else if (state == IDLE && frame_start) begin
      words_written <= '0;
    end else if (commit && !(&words_written)) begin
      words_written <= words_written + (ADDR_W+1)'(1);
    end
  end
`endif

  assign sram_write_enable  = pending;
  assign sram_write_address = addr;
  assign sram_write_data    = word_q;
  assign frame_done         = done_q;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_output_pack_writer.sv
// tb_output_pack_writer
//   Scoreboard bench for output_pack_writer. Each frame's expected SRAM
//   writes are computed from its element list (chunk into words, zero-fill,
//   consecutive wrapping addresses) and queued when the frame is issued; a
//   negedge monitor pops and compares on every commit, and also checks
//   frame_done timing, stall hold behaviour and in_ready back-pressure.
`timescale 1ns/1ps

module tb_output_pack_writer;

  localparam int ELEM_W = 8;
  localparam int EPW    = 2;
  localparam int ADDR_W = 12;
  localparam int WORD_W = ELEM_W * EPW;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              sram_ready = 1'b1;
  logic              in_ready;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] sram_write_address;
  logic [WORD_W-1:0] sram_write_data;
  logic              frame_done;
  logic              busy;
`ifdef OUTPUT_PACK_WORD_COUNT_EN
  logic [ADDR_W:0]   words_written;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    bit                last;
    int                nwords;
  } exp_t;

  exp_t              expQ[$];
  exp_t              popped;
  logic [ELEM_W-1:0] elemQ[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;
  int readyMode   = 0;
  int stallCnt    = 0;

  bit                holdDue = 1'b0;
  bit                doneDue = 1'b0;
  int                doneWords = 0;
  logic [ADDR_W-1:0] holdAddr;
  logic [WORD_W-1:0] holdData;

  always #5 clk = ~clk;

  output_pack_writer #(
    .ELEM_W(ELEM_W),
    .ELEMS_PER_WORD(EPW),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .frame_start(frame_start),
    .base_addr(base_addr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .sram_write_enable(sram_write_enable),
    .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data),
    .sram_ready(sram_ready),
`ifdef OUTPUT_PACK_WORD_COUNT_EN
    .words_written(words_written),
`endif
    .frame_done(frame_done),
    .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // SRAM grant: 0 = always granted, 1 = random, 2 = withhold for the first
  // three stalled cycles then grant forever.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       sram_ready = 1'b1;
      1:       sram_ready = ($urandom_range(0, 3) != 0);
      default: sram_ready = (stallCnt >= 3);
    endcase
  end

  // Monitor: everything observed at the negedge, away from the active edge.
  always @(negedge clk) begin
    if (!reset_b) begin
      holdDue = 1'b0;
      doneDue = 1'b0;
    end else begin
      if (doneDue) begin
        checkOutput("frame_done pulse", 64'(frame_done), 64'(1));
        checkOutput("busy after done", 64'(busy), 64'(0));
`ifdef OUTPUT_PACK_WORD_COUNT_EN
        checkOutput("words_written", 64'(words_written), 64'(doneWords));
`endif
        doneDue = 1'b0;
        doneCount++;
      end else if (frame_done) begin
        checkOutput("spurious frame_done", 64'(frame_done), 64'(0));
      end

      if (holdDue) begin
        checkOutput("hold enable", 64'(sram_write_enable), 64'(1));
        checkOutput("hold address", 64'(sram_write_address), 64'(holdAddr));
        checkOutput("hold data", 64'(sram_write_data), 64'(holdData));
      end
      holdDue = 1'b0;

      if (sram_write_enable && !sram_ready) begin
        checkOutput("in_ready while stalled", 64'(in_ready), 64'(0));
        holdDue  = 1'b1;
        holdAddr = sram_write_address;
        holdData = sram_write_data;
        stallCnt++;
      end

      if (sram_write_enable && sram_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected write", 64'(sram_write_enable), 64'(0));
        end else begin
          popped = expQ.pop_front();
          checkOutput("write address", 64'(sram_write_address), 64'(popped.addr));
          checkOutput("write data", 64'(sram_write_data), 64'(popped.data));
          if (popped.last) begin
            doneDue   = 1'b1;
            doneWords = popped.nwords;
          end
        end
      end
    end
  end

  task automatic sendElem(input logic [ELEM_W-1:0] d, input bit last, input bit inject);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (inject) begin
      frame_start = 1'b1;
      base_addr   = 12'h555;
    end
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (in_ready) break;
      if (c > 300) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL in_ready timeout: got 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_start = 1'b0;
  endtask

  // Issues one frame from elemQ and queues the writes it must produce.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int injectAt,
                               input bit gaps);
    int   n;
    int   nw;
    int   startDone;
    int   cnt;
    exp_t e;
    n  = elemQ.size();
    nw = (n + EPW - 1) / EPW;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int l = 0; l < EPW; l++) begin
        if (w * EPW + l < n) begin
          e.data = e.data | (WORD_W'(elemQ[w*EPW+l]) << ((EPW - 1 - l) * ELEM_W));
        end
      end
      e.addr   = base + ADDR_W'(w);
      e.last   = (w == nw - 1);
      e.nwords = nw;
      expQ.push_back(e);
    end
    startDone   = doneCount;
    frame_start = 1'b1;
    base_addr   = base;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    base_addr   = ADDR_W'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      sendElem(elemQ[i], (i == n - 1), (i == injectAt));
    end
    cnt = 0;
    while (doneCount == startDone && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (doneCount == startDone) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL frame completion: got no frame_done, expected one");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    checkOutput("reset enable", 64'(sram_write_enable), 64'(0));
    checkOutput("reset address", 64'(sram_write_address), 64'(0));
    checkOutput("reset data", 64'(sram_write_data), 64'(0));
    checkOutput("reset in_ready", 64'(in_ready), 64'(0));
    checkOutput("reset frame_done", 64'(frame_done), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with a zero-filled tail word.
    readyMode = 0;
    elemQ = '{8'hA1, 8'hB2, 8'hC3};
    applyStimulus(12'h010, -1, 1'b0);

    // Three cycles of withheld grant while a word is pending.
    stallCnt  = 0;
    readyMode = 2;
    elemQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(12'h100, -1, 1'b0);
    readyMode = 0;

    // Address wrap.
    elemQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(12'hFFF, -1, 1'b0);

    // frame_start during ACTIVE must be ignored.
    elemQ = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    applyStimulus(12'h040, 2, 1'b0);

    // Reset mid-word: nothing written, outputs cleared, clean restart.
    frame_start = 1'b1;
    base_addr   = 12'h200;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    sendElem(8'hA1, 1'b0, 1'b0);
    reset_b = 1'b0;
    #1;
    checkOutput("mid-frame reset enable", 64'(sram_write_enable), 64'(0));
    checkOutput("mid-frame reset address", 64'(sram_write_address), 64'(0));
    checkOutput("mid-frame reset data", 64'(sram_write_data), 64'(0));
    checkOutput("mid-frame reset in_ready", 64'(in_ready), 64'(0));
    checkOutput("mid-frame reset busy", 64'(busy), 64'(0));
    checkOutput("mid-frame reset frame_done", 64'(frame_done), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    elemQ = '{8'h5A, 8'hC6, 8'h7E};
    applyStimulus(12'h123, -1, 1'b0);

    // Randomized frames with random grants and input gaps.
    readyMode = 1;
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 9);
      elemQ.delete();
      for (int i = 0; i < n; i++) elemQ.push_back(ELEM_W'($urandom));
      applyStimulus(ADDR_W'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1,
                    1'b1);
    end
    readyMode = 0;

    checkOutput("scoreboard empty", 64'(expQ.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/output_pack_writer.md
OUTPUT_PACK_WRITER -- requirements
Module: output_pack_writer

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, meaning the bit width of one pooled output element.
REQ-002 SHALL have parameter ELEMS_PER_WORD, default 2, meaning elements packed per SRAM word; legal values are powers of 2 and at least 2.
REQ-003 SHALL have parameter ADDR_W, default 12, meaning the SRAM address width; the word width WORD_W SHALL equal ELEM_W*ELEMS_PER_WORD.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse that opens a frame.
REQ-007 SHALL have port base_addr, input, ADDR_W bits: first word address of a frame, sampled on an accepted frame_start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, ELEM_W) and in_last (input, 1): the element stream; in_last marks the final element of the frame.
REQ-009 SHALL have ports sram_write_enable (output, 1), sram_write_address (output, ADDR_W) and sram_write_data (output, WORD_W): the SRAM write port.
REQ-010 SHALL have port sram_ready, input, 1 bit: SRAM grant; a write commits only in a cycle where sram_write_enable and sram_ready are both 1.
REQ-011 SHALL have ports frame_done (output, 1: one-cycle completion pulse) and busy (output, 1: high when state is not IDLE).

Function
REQ-012 SHALL implement the states IDLE, ACTIVE and DRAIN.
REQ-013 SHALL leave IDLE for ACTIVE only when frame_start=1; it SHALL then load the write address from base_addr and clear the lane counter.
REQ-014 SHALL ignore frame_start while in ACTIVE or DRAIN.
REQ-015 SHALL drive in_ready=1 only in ACTIVE, and only when no write is pending or the pending write commits in the current cycle.
REQ-016 SHALL accept an element exactly when in_valid and in_ready are both 1.
REQ-017 SHALL place the element with lane index k at bits [WORD_W-1-k*ELEM_W -: ELEM_W], so lane 0 occupies the MSBs.
REQ-018 SHALL advance the lane counter modulo ELEMS_PER_WORD on each accepted element.
REQ-019 SHALL close the word being built when it accepts lane ELEMS_PER_WORD-1, or when it accepts any element with in_last=1.
REQ-020 SHALL zero-fill every unfilled lane when a word closes on in_last.
REQ-021 SHALL register a closed word as pending and assert sram_write_enable in the next cycle (latency 1), holding address and data stable until commit.
REQ-022 SHALL drive sram_write_enable only from the pending flag and SHALL NOT write in any other cycle.
REQ-023 SHALL increment the write address by 1 on each commit, wrapping from 2^ADDR_W-1 to 0.
REQ-024 SHALL sustain one element per cycle while sram_ready=1, with no bubble at word boundaries.
REQ-025 SHALL move from ACTIVE to DRAIN on an accepted in_last.
REQ-026 SHALL, in DRAIN, pulse frame_done for one cycle in the cycle after the final commit and return to IDLE in that same cycle.
REQ-027 SHALL NOT write a word when in_last arrives with no elements after a closed word; every frame ends with exactly one write for its final word.

Reset
REQ-028 SHALL, on reset_b=0, immediately and asynchronously force: state IDLE, pending cleared, lane counter 0, address 0, sram_write_enable=0, sram_write_address=0, sram_write_data=0, in_ready=0, frame_done=0, busy=0.
REQ-029 SHALL, on reset mid-frame, discard any partial or pending word without writing it.

Configuration
REQ-030 SHALL provide a word-count output under macro OUTPUT_PACK_WORD_COUNT_EN.
- Defined: adds output words_written (ADDR_W+1 bits), cleared on an accepted frame_start and on reset, incremented per commit, saturating at all-ones, held after frame_done.
- Undefined: port and counter absent; all other behaviour identical.

Verification (ELEM_W=8, ELEMS_PER_WORD=2, ADDR_W=12)
REQ-031 SHALL cover: frame_start with base_addr=0x010, stream A1,B2,C3(last) with sram_ready=1 -> writes 0xA1B2@0x010 then 0xC300@0x011; frame_done pulses one cycle after the second write; busy=0 afterwards.
REQ-032 SHALL cover: sram_ready=0 for 3 cycles while a word is pending -> enable, address and data held; in_ready=0 after the next word closes; no data lost; writes commit in order once sram_ready=1.
REQ-033 SHALL cover: base_addr=0xFFF with a 4-element frame -> writes at 0xFFF then 0x000.
REQ-034 SHALL cover: frame_start asserted during ACTIVE -> ignored; the address sequence continues unchanged.
REQ-035 SHALL cover: reset_b pulsed low after one element of a word -> no write occurs, all outputs are 0, and the next frame starts cleanly at its base_addr.
REQ-036 SHALL cover, with OUTPUT_PACK_WORD_COUNT_EN defined: a 5-element frame -> words_written=3 at frame_done.
